// File: rtl/shift_8_bit_seq_pkg.sv
// Shared op and state encodings for the multi-cycle shift sequencer.
package shift_8_bit_seq_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_8_bit_as.sv
// Single-position 8-bit shifter: left/right, optional arithmetic right, external fill bits.
module shift_8_bit_as (
    input  logic [7:0] din,
    input  logic       select,
    input  logic       ar_select,
    input  logic       fill_left,
    input  logic       fill_right,
    output logic [7:0] dout,
    output logic       bb_left,
    output logic       bb_right
);

    logic msb_in;

    always_comb begin
        // Arithmetic right shift replicates the sign bit instead of taking the fill.
        msb_in = ar_select ? din[7] : fill_right;
        if (select) begin
            dout = {msb_in, din[7:1]};
        end else begin
            dout = {din[6:0], fill_left};
        end
    end

    assign bb_left  = din[7];
    assign bb_right = din[0];

endmodule

// File: rtl/shift_8_bit_seq.sv
// Multi-cycle shift sequencer: one single-bit shift per clock, valid/ready in and out.
// Define SHIFT_SEQ_ROTATE_EN to make op 11 rotate right; otherwise it behaves as SRL.
module shift_8_bit_seq
    import shift_8_bit_seq_pkg::*;
#(
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       din,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       dout,
    output logic             carry,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;

    logic [7:0] sh_out;
    logic       sh_bb_left;
    logic       sh_bb_right;
    logic       shift_right;
    logic       fill_right;
    logic       shift_carry;

    assign shift_right = (op_q != OP_SLL);

`ifdef SHIFT_SEQ_ROTATE_EN
    assign fill_right = (op_q == OP_ROR) ? data_q[0] : 1'b0;
`else
    assign fill_right = 1'b0;
`endif

    shift_8_bit_as u_shifter (
        .din        (data_q),
        .select     (shift_right),
        .ar_select  (op_q == OP_SRA),
        .fill_left  (1'b0),
        .fill_right (fill_right),
        .dout       (sh_out),
        .bb_left    (sh_bb_left),
        .bb_right   (sh_bb_right)
    );

    assign shift_carry = shift_right ? sh_bb_right : sh_bb_left;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = din;
                    op_d    = op;
                    cnt_d   = amt;
                    carry_d = 1'b0;
                    state_d = (amt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                data_d  = sh_out;
                carry_d = shift_carry;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign dout      = data_q;
    assign carry     = carry_q;

endmodule
